// File: rtl/uart_tx_frame.sv
// UART transmitter with an input FIFO. The frame format (data width, parity,
// stop bits, bit period) is fixed at elaboration; queued characters leave back-to-back.
module uart_tx_frame #(
   parameter int CLK_DIV    = 104,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [DATA_BITS-1:0]        in_data,
   output logic                        in_ready,
   output logic                        drop,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TICK_END = TW'(CLK_DIV - 1);
   localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wptr, r_rptr;
   logic [AW:0]          r_count;
   state_t               r_state;
   logic [TW-1:0]        r_tick;
   logic [BW-1:0]        r_bitcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_tx;
   logic                 r_busy;

   logic                 w_empty, w_push, w_pop, w_bit_end, w_bit_val;
   logic [DATA_BITS-1:0] w_head;

   assign w_empty   = (r_count == '0);
   assign in_ready  = (r_count < DEPTH_C);
   assign w_push    = in_valid & in_ready;
   assign drop      = in_valid & ~in_ready;
   assign w_bit_end = (r_tick == TICK_END);
   assign w_head    = r_mem[r_rptr];
   // The FIFO is read only when the line is free: from IDLE, or at the very
   // last clock of the final stop bit so the next start bit follows with no gap.
   assign w_pop = ~w_empty & ((r_state == S_IDLE) |
                  ((r_state == S_STOP) & w_bit_end & (r_bitcnt == STOP_END)));

   assign level = r_count;
   assign tx    = r_tx;
   assign busy  = r_busy;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_bit_val = 1'b1;
      case (r_state)
         S_START:  w_bit_val = 1'b0;
         S_DATA:   w_bit_val = r_shift[0];
         S_PARITY: w_bit_val = r_par;
         default:  w_bit_val = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_tick   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_tx   <= w_bit_val;
         r_busy <= (r_state != S_IDLE) | ~w_empty;
         if (r_state == S_IDLE) begin
            r_tick   <= '0;
            r_bitcnt <= '0;
            if (w_pop) r_state <= S_START;
         end else if (!w_bit_end) begin
            r_tick <= r_tick + 1'b1;
         end else begin
            r_tick <= '0;
            case (r_state)
               S_START: begin
                  r_state  <= S_DATA;
                  r_bitcnt <= '0;
               end
               S_DATA: begin
                  if (r_bitcnt == DATA_END) begin
                     r_state  <= (PARITY != 0) ? S_PARITY : S_STOP;
                     r_bitcnt <= '0;
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                     r_shift  <= r_shift >> 1;
                  end
               end
               S_PARITY: begin
                  r_state  <= S_STOP;
                  r_bitcnt <= '0;
               end
               S_STOP: begin
                  if (r_bitcnt == STOP_END) begin
                     r_state  <= w_pop ? S_START : S_IDLE;
                     r_bitcnt <= '0;
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
         // Parity is computed once at load, since the shifter consumes the data.
         if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
         end
      end
   end
endmodule
